// File: rtl/issue_scoreboard.sv
// Purpose: in-order single-issue stage; holds one decoded instruction, tracks pending GPR
//          writes in a 32-bit scoreboard and steers the instruction to the ALU, MEM or BRU unit.
// Latency: accept in cycle N, earliest issue in N+1; a syscall drains everything and then
//          raises sys_req until sys_ack.
// Backpressure: in_ready only when the holder is empty or fires this cycle. Issue stalls on a
//          RAW/WAW hazard or when the target unit is full. Once raised, a unit valid holds
//          with a stable payload until its ready.
// Ports: clk/rst_n; flush; in_* decoded instruction (valid/ready); alu_/mem_/bru_ valid/ready
//        issue handshakes; out_payload/out_dst_lr from the held instruction; *_done retire
//        strobes; wb_valid/wb_lr scoreboard clear; sys_req/sys_ack syscall handshake.
module issue_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int PAYLOAD_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_read_rs,
    input  logic [4:0]           in_rs,
    input  logic                 in_read_rt,
    input  logic [4:0]           in_rt,
    input  logic                 in_write_gpr,
    input  logic [4:0]           in_dst_lr,
    input  logic                 in_mem,
    input  logic                 in_cf,
    input  logic                 in_syscall,
    output logic                 alu_valid,
    output logic                 mem_valid,
    output logic                 bru_valid,
    input  logic                 alu_ready,
    input  logic                 mem_ready,
    input  logic                 bru_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [4:0]           out_dst_lr,
    input  logic                 alu_done,
    input  logic                 mem_done,
    input  logic                 bru_done,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_lr,
    output logic                 sys_req,
    input  logic                 sys_ack
);

    typedef enum logic [1:0] {EMPTY, HOLD, SYS_DRAIN, SYS_REQ} state_t;
    typedef enum logic [1:0] {U_ALU, U_MEM, U_BRU} unit_t;

    state_t      state, state_next;
    unit_t       h_unit;
    logic        h_read_rs, h_read_rt, h_write;
    logic [4:0]  h_rs, h_rt;
    logic [31:0] sb;
    logic [3:0]  cnt_alu, cnt_mem, cnt_bru;

    logic [31:0] wb_mask, sb_eff, set_mask;
    logic [3:0]  cnt_sel;
    logic        hazard, issue_ok, fire, accept;
    logic        alu_fire, mem_fire, bru_fire;

    // A write-back landing this cycle already unblocks the held instruction.
    always_comb begin
        wb_mask = wb_valid ? (32'd1 << wb_lr) : 32'd0;
        sb_eff  = sb & ~wb_mask;
        hazard  = (h_read_rs & sb_eff[h_rs]) |
                  (h_read_rt & sb_eff[h_rt]) |
                  (h_write   & sb_eff[out_dst_lr]);
    end

    always_comb begin
        case (h_unit)
            U_MEM:   cnt_sel = cnt_mem;
            U_BRU:   cnt_sel = cnt_bru;
            default: cnt_sel = cnt_alu;
        endcase
    end

    // Unit occupancy uses the registered count only; a same-cycle done frees the slot next cycle.
    assign issue_ok  = (state == HOLD) && !hazard && (cnt_sel < 4'(MAX_OUTSTANDING));
    assign alu_valid = issue_ok && (h_unit == U_ALU);
    assign mem_valid = issue_ok && (h_unit == U_MEM);
    assign bru_valid = issue_ok && (h_unit == U_BRU);
    assign alu_fire  = alu_valid & alu_ready;
    assign mem_fire  = mem_valid & mem_ready;
    assign bru_fire  = bru_valid & bru_ready;
    assign fire      = alu_fire | mem_fire | bru_fire;
    assign in_ready  = !flush && ((state == EMPTY) || fire);
    assign accept    = in_valid & in_ready;
    assign sys_req   = (state == SYS_REQ);
    assign set_mask  = (fire && h_write && (out_dst_lr != 5'd0)) ? (32'd1 << out_dst_lr) : 32'd0;

    always_comb begin
        state_next = state;
        case (state)
            EMPTY, HOLD: begin
                if (accept)
                    state_next = in_syscall ? SYS_DRAIN : HOLD;
                else if (fire)
                    state_next = EMPTY;
            end
            SYS_DRAIN: begin
                if (sb == 32'd0 && cnt_alu == 4'd0 && cnt_mem == 4'd0 && cnt_bru == 4'd0)
                    state_next = SYS_REQ;
            end
            SYS_REQ: begin
                if (sys_ack)
                    state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
        if (flush)
            state_next = EMPTY;
    end

    // Done at zero is dropped; issue plus done in one cycle leaves the count unchanged.
    function automatic logic [3:0] cnt_upd(input logic [3:0] cur, input logic inc,
                                           input logic done);
        logic dec;
        dec = done && (cur != 4'd0);
        case ({inc, dec})
            2'b10:   cnt_upd = cur + 4'd1;
            2'b01:   cnt_upd = cur - 4'd1;
            default: cnt_upd = cur;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            sb          <= 32'd0;
            cnt_alu     <= 4'd0;
            cnt_mem     <= 4'd0;
            cnt_bru     <= 4'd0;
            h_unit      <= U_ALU;
            h_read_rs   <= 1'b0;
            h_read_rt   <= 1'b0;
            h_write     <= 1'b0;
            h_rs        <= 5'd0;
            h_rt        <= 5'd0;
            out_payload <= '0;
            out_dst_lr  <= 5'd0;
        end else begin
            state   <= state_next;
            // Set after clear so an issue beats a same-cycle write-back of that register.
            sb      <= ((sb & ~wb_mask) | set_mask) & ~32'd1;
            cnt_alu <= cnt_upd(cnt_alu, alu_fire, alu_done);
            cnt_mem <= cnt_upd(cnt_mem, mem_fire, mem_done);
            cnt_bru <= cnt_upd(cnt_bru, bru_fire, bru_done);
            if (accept) begin
                h_unit      <= in_mem ? U_MEM : (in_cf ? U_BRU : U_ALU);
                h_read_rs   <= in_read_rs;
                h_read_rt   <= in_read_rt;
                h_write     <= in_write_gpr;
                h_rs        <= in_rs;
                h_rt        <= in_rt;
                out_payload <= in_payload;
                out_dst_lr  <= in_dst_lr;
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

    logic        clk, rst_n, flush;
    logic        in_valid, in_ready;
    logic [31:0] in_payload;
    logic        in_read_rs, in_read_rt, in_write_gpr, in_mem, in_cf, in_syscall;
    logic [4:0]  in_rs, in_rt, in_dst_lr;
    logic        alu_valid, mem_valid, bru_valid, alu_ready, mem_ready, bru_ready;
    logic [31:0] out_payload;
    logic [4:0]  out_dst_lr;
    logic        alu_done, mem_done, bru_done, wb_valid;
    logic [4:0]  wb_lr;
    logic        sys_req, sys_ack;
    logic [4:0]  st;
    int          checks = 0;
    int          failures = 0;

    // {in_ready, alu_valid, mem_valid, bru_valid, sys_req}
    assign st = {in_ready, alu_valid, mem_valid, bru_valid, sys_req};

    issue_scoreboard #(.MAX_OUTSTANDING(2), .PAYLOAD_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_read_rs(in_read_rs), .in_rs(in_rs), .in_read_rt(in_read_rt), .in_rt(in_rt),
        .in_write_gpr(in_write_gpr), .in_dst_lr(in_dst_lr),
        .in_mem(in_mem), .in_cf(in_cf), .in_syscall(in_syscall),
        .alu_valid(alu_valid), .mem_valid(mem_valid), .bru_valid(bru_valid),
        .alu_ready(alu_ready), .mem_ready(mem_ready), .bru_ready(bru_ready),
        .out_payload(out_payload), .out_dst_lr(out_dst_lr),
        .alu_done(alu_done), .mem_done(mem_done), .bru_done(bru_done),
        .wb_valid(wb_valid), .wb_lr(wb_lr), .sys_req(sys_req), .sys_ack(sys_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_in();
        in_valid = 0; in_payload = 0; in_read_rs = 0; in_rs = 0; in_read_rt = 0; in_rt = 0;
        in_write_gpr = 0; in_dst_lr = 0; in_mem = 0; in_cf = 0; in_syscall = 0;
    endtask

    task automatic offer(input logic [31:0] p, input logic rrs, input logic [4:0] rs,
                         input logic rrt, input logic [4:0] rt, input logic wr,
                         input logic [4:0] dst, input logic m, input logic cf, input logic sc);
        in_valid = 1; in_payload = p; in_read_rs = rrs; in_rs = rs; in_read_rt = rrt;
        in_rt = rt; in_write_gpr = wr; in_dst_lr = dst; in_mem = m; in_cf = cf;
        in_syscall = sc;
    endtask

    // One-cycle retire pulse for unit u (0 alu, 1 mem, 2 bru), optionally with a write-back.
    task automatic retire(input int u, input logic wr, input logic [4:0] lr);
        alu_done = (u == 0); mem_done = (u == 1); bru_done = (u == 2);
        wb_valid = wr; wb_lr = lr;
        step();
        alu_done = 0; mem_done = 0; bru_done = 0; wb_valid = 0; wb_lr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; flush = 0; clear_in();
        alu_ready = 0; mem_ready = 0; bru_ready = 0;
        alu_done = 0; mem_done = 0; bru_done = 0; wb_valid = 0; wb_lr = 0; sys_ack = 0;
        repeat (2) @(posedge clk);
        mid();
        checks++; if (st !== 5'b10000) begin failures++; $display("FAIL reset_flags got=%b exp=%b", st, 5'b10000); end
        checks++; if (out_payload !== 32'd0) begin failures++; $display("FAIL reset_payload got=%h exp=0", out_payload); end
        checks++; if (out_dst_lr !== 5'd0) begin failures++; $display("FAIL reset_dst got=%0d exp=0", out_dst_lr); end
        rst_n = 1;
        step();
    endtask

    task automatic test_alu_basic();
        alu_ready = 1;
        offer(32'h00221821, 1, 1, 1, 2, 1, 3, 0, 0, 0);
        mid();
        checks++; if (st !== 5'b10000) begin failures++; $display("FAIL alu_accept got=%b exp=%b", st, 5'b10000); end
        step(); clear_in(); mid();
        checks++; if (st !== 5'b11000) begin failures++; $display("FAIL alu_issue_n1 got=%b exp=%b", st, 5'b11000); end
        checks++; if (out_dst_lr !== 5'd3) begin failures++; $display("FAIL alu_dst got=%0d exp=3", out_dst_lr); end
        checks++; if (out_payload !== 32'h00221821) begin failures++; $display("FAIL alu_payload got=%h exp=00221821", out_payload); end
        step();
        offer(32'h00603821, 1, 3, 1, 0, 1, 7, 0, 0, 0);
        mid(); step(); clear_in(); mid();
        checks++; if (st !== 5'b00000) begin failures++; $display("FAIL raw_r3_stall got=%b exp=%b", st, 5'b00000); end
        step();
        wb_valid = 1; wb_lr = 3; mid();
        checks++; if (st !== 5'b11000) begin failures++; $display("FAIL wb_r3_release got=%b exp=%b", st, 5'b11000); end
        step(); wb_valid = 0; wb_lr = 0;
        retire(0, 0, 0); retire(0, 1, 7);
    endtask

    task automatic test_raw_bypass();
        mem_ready = 1;
        offer(32'h8C250000, 1, 1, 0, 0, 1, 5, 1, 0, 0);
        mid(); step();
        offer(32'h00A03021, 1, 5, 1, 0, 1, 6, 0, 0, 0);
        mid();
        checks++; if (st !== 5'b10100) begin failures++; $display("FAIL lw_issue got=%b exp=%b", st, 5'b10100); end
        step(); clear_in(); mid();
        checks++; if (st !== 5'b00000) begin failures++; $display("FAIL raw_r5_stall got=%b exp=%b", st, 5'b00000); end
        step(); mid();
        checks++; if (st !== 5'b00000) begin failures++; $display("FAIL raw_r5_stall2 got=%b exp=%b", st, 5'b00000); end
        step();
        wb_valid = 1; wb_lr = 5; mid();
        checks++; if (st !== 5'b11000) begin failures++; $display("FAIL raw_r5_bypass got=%b exp=%b", st, 5'b11000); end
        checks++; if (out_dst_lr !== 5'd6) begin failures++; $display("FAIL raw_dst got=%0d exp=6", out_dst_lr); end
        step(); wb_valid = 0; wb_lr = 0;
        retire(1, 0, 0); retire(0, 1, 6);
    endtask

    task automatic test_waw();
        offer(32'h00224821, 1, 1, 0, 0, 1, 9, 0, 0, 0);
        mid(); step();
        offer(32'h00404821, 1, 2, 0, 0, 1, 9, 0, 0, 0);
        mid();
        checks++; if (st !== 5'b11000) begin failures++; $display("FAIL waw_first_issue got=%b exp=%b", st, 5'b11000); end
        step(); clear_in(); mid();
        checks++; if (st !== 5'b00000) begin failures++; $display("FAIL waw_stall got=%b exp=%b", st, 5'b00000); end
        step();
        wb_valid = 1; wb_lr = 9; alu_done = 1; mid();
        checks++; if (st !== 5'b11000) begin failures++; $display("FAIL waw_release got=%b exp=%b", st, 5'b11000); end
        step(); wb_valid = 0; wb_lr = 0; alu_done = 0;
        // r9 must still be pending: the issue beat the same-cycle write-back.
        offer(32'h01206021, 1, 9, 0, 0, 1, 12, 0, 0, 0);
        mid(); step(); clear_in(); mid();
        checks++; if (st !== 5'b00000) begin failures++; $display("FAIL set_wins_over_wb got=%b exp=%b", st, 5'b00000); end
        retire(0, 1, 9); retire(0, 1, 12);
    endtask

    task automatic test_back_to_back();
        mem_ready = 1;
        offer(32'hAE000001, 1, 1, 1, 2, 0, 0, 1, 0, 0);
        mid(); step();
        offer(32'hAE000002, 1, 1, 1, 2, 0, 0, 1, 0, 0);
        mid();
        checks++; if (st !== 5'b10100 || out_payload !== 32'hAE000001) begin failures++; $display("FAIL sw1_issue got=%b/%h exp=10100/ae000001", st, out_payload); end
        step();
        offer(32'hAE000003, 1, 1, 1, 2, 0, 0, 1, 0, 0);
        mid();
        checks++; if (st !== 5'b10100 || out_payload !== 32'hAE000002) begin failures++; $display("FAIL sw2_issue got=%b/%h exp=10100/ae000002", st, out_payload); end
        step(); clear_in(); mid();
        checks++; if (st !== 5'b00000 || out_payload !== 32'hAE000003) begin failures++; $display("FAIL mem_full_stall got=%b/%h exp=00000/ae000003", st, out_payload); end
        step();
        mem_done = 1; mid();
        checks++; if (st !== 5'b00000) begin failures++; $display("FAIL no_done_bypass got=%b exp=%b", st, 5'b00000); end
        step(); mem_done = 0; mid();
        checks++; if (st !== 5'b10100) begin failures++; $display("FAIL issue_after_done got=%b exp=%b", st, 5'b10100); end
        step(); mid();
        checks++; if (st !== 5'b10000) begin failures++; $display("FAIL b2b_empty got=%b exp=%b", st, 5'b10000); end
        retire(1, 0, 0); retire(1, 0, 0);
    endtask

    task automatic test_r0();
        offer(32'h34200005, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        mid(); step();
        offer(32'h00004021, 1, 0, 1, 0, 1, 8, 0, 0, 0);
        mid();
        checks++; if (st !== 5'b11000 || out_dst_lr !== 5'd0) begin failures++; $display("FAIL r0_write_issue got=%b/%0d exp=11000/0", st, out_dst_lr); end
        step(); clear_in(); mid();
        checks++; if (st !== 5'b11000 || out_dst_lr !== 5'd8) begin failures++; $display("FAIL r0_no_stall got=%b/%0d exp=11000/8", st, out_dst_lr); end
        step();
        retire(0, 0, 0); retire(0, 1, 8);
    endtask

    task automatic test_syscall();
        int n;
        mem_ready = 1;
        offer(32'h8C240000, 1, 1, 0, 0, 1, 4, 1, 0, 0);
        mid(); step();
        offer(32'h0000000C, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        mid();
        checks++; if (st !== 5'b10100) begin failures++; $display("FAIL lw_r4_issue got=%b exp=%b", st, 5'b10100); end
        step(); clear_in(); mid();
        checks++; if (st !== 5'b00000) begin failures++; $display("FAIL drain_wait got=%b exp=%b", st, 5'b00000); end
        step();
        wb_valid = 1; wb_lr = 4; mid();
        checks++; if (st !== 5'b00000) begin failures++; $display("FAIL drain_wb_only got=%b exp=%b", st, 5'b00000); end
        step(); wb_valid = 0; wb_lr = 0;
        mem_done = 1; mid();
        checks++; if (st !== 5'b00000) begin failures++; $display("FAIL drain_done_cycle got=%b exp=%b", st, 5'b00000); end
        step(); mem_done = 0;
        n = 0; mid();
        while (sys_req !== 1'b1 && n < 4) begin step(); mid(); n++; end
        checks++; if (sys_req !== 1'b1) begin failures++; $display("FAIL sys_req_timeout got=%b exp=1", sys_req); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (st !== 5'b00001) begin failures++; $display("FAIL sys_req_hold%0d got=%b exp=%b", i, st, 5'b00001); end
            if (i == 2) sys_ack = 1;
            step();
        end
        sys_ack = 0; mid();
        checks++; if (st !== 5'b10000) begin failures++; $display("FAIL sys_ack_empty got=%b exp=%b", st, 5'b10000); end
        step();
    endtask

    task automatic test_flush_and_reset();
        alu_ready = 1; bru_ready = 0;
        offer(32'h00225021, 1, 1, 0, 0, 1, 10, 0, 0, 0);
        mid(); step();
        offer(32'h10220003, 1, 1, 1, 2, 0, 0, 0, 1, 0);
        mid(); step(); clear_in(); mid();
        checks++; if (st !== 5'b00010) begin failures++; $display("FAIL bru_wait got=%b exp=%b", st, 5'b00010); end
        step(); mid();
        checks++; if (st !== 5'b00010 || out_payload !== 32'h10220003) begin failures++; $display("FAIL bru_stable got=%b/%h exp=00010/10220003", st, out_payload); end
        step();
        flush = 1;
        offer(32'h01405821, 1, 10, 0, 0, 1, 11, 0, 0, 0);
        mid();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_no_accept got=%b exp=0", in_ready); end
        step(); flush = 0; mid();
        checks++; if (st !== 5'b10000) begin failures++; $display("FAIL after_flush_empty got=%b exp=%b", st, 5'b10000); end
        step(); clear_in(); mid();
        checks++; if (st !== 5'b00000 || out_dst_lr !== 5'd11) begin failures++; $display("FAIL sb_kept_after_flush got=%b/%0d exp=00000/11", st, out_dst_lr); end
        #1 rst_n = 0;
        #1;
        checks++; if (st !== 5'b10000) begin failures++; $display("FAIL async_reset_flags got=%b exp=%b", st, 5'b10000); end
        checks++; if (out_payload !== 32'd0 || out_dst_lr !== 5'd0) begin failures++; $display("FAIL async_reset_data got=%h/%0d exp=0/0", out_payload, out_dst_lr); end
        #1 rst_n = 1;
        step();
        offer(32'h01406821, 1, 10, 0, 0, 1, 13, 0, 0, 0);
        mid(); step(); clear_in(); mid();
        checks++; if (st !== 5'b11000) begin failures++; $display("FAIL sb_cleared_by_reset got=%b exp=%b", st, 5'b11000); end
        step();
        retire(0, 1, 13);
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_raw_bypass();
        test_waw();
        test_back_to_back();
        test_r0();
        test_syscall();
        test_flush_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
